// File: rtl/uart_pkg.sv
// Shared definitions for the UART command master: FSM states,
// parity modes and the parity helper used by tx and rx paths.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        IDLE     = 4'd0,
        TX_START = 4'd1,
        TX_DATA  = 4'd2,
        TX_PAR   = 4'd3,
        TX_STOP  = 4'd4,
        TX_GAP   = 4'd5,
        RX_WAIT  = 4'd6,
        RX_START = 4'd7,
        RX_DATA  = 4'd8,
        RX_PAR   = 4'd9,
        RX_STOP  = 4'd10,
        DONE     = 4'd11
    } state_t;

    // Parity bit that makes the frame even/odd for the given mode
    function automatic logic par_bit(input logic [7:0] d, input int mode);
        par_bit = (mode == PARITY_ODD) ? ~(^d) : ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: wraps every CLK_PER_BIT cycles, held at 0 while
// restart is high; mid strobes half a bit in, tick on the last cycle.
module uart_bit_timer #(
    parameter int CLK_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic mid,
    output logic tick
);

    localparam int W = $clog2(CLK_PER_BIT);

    logic [W-1:0] cnt;

    // Free-running bit counter with synchronous restart
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (cnt == W'(CLK_PER_BIT - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign mid  = !restart && (cnt == W'(CLK_PER_BIT / 2));
    assign tick = !restart && (cnt == W'(CLK_PER_BIT - 1));

endmodule

// File: rtl/uart_cmd_master.sv
// UART command master: serialises write/read commands on tx and
// collects read responses from rx. Optional UART_RX_TIMEOUT_EN.
module uart_cmd_master #(
    parameter int CLK_PER_BIT  = 434,
    parameter int CMD_BYTES    = 2,
    parameter int RD_BYTES     = 1,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1,
    parameter int GAP_BITS     = 2,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*CMD_BYTES-1:0] cmd_in,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    output logic                  tx,
    input  logic                  rx,
    output logic                  rd_vld,
    output logic [8*RD_BYTES-1:0] rd_data,
    output logic [2:0]            rd_err
);

    import uart_pkg::*;

    localparam int MAXB = (CMD_BYTES > RD_BYTES) ? CMD_BYTES : RD_BYTES;
    localparam int BYW  = $clog2(MAXB + 1);
    localparam int NB0  = (GAP_BITS > 8) ? GAP_BITS : 8;
    localparam int NB   = (STOP_BITS > NB0) ? STOP_BITS : NB0;
    localparam int IW   = $clog2(NB);

    state_t state, state_n;

    logic                  mid, tick, restart;
    logic                  rx_m, rx_s, rx_d, fall;
    logic [IW-1:0]         bit_idx;
    logic [BYW-1:0]        byte_idx;
    logic [8*CMD_BYTES-1:0] cmd_q;
    logic                  is_rd;
    logic [7:0]            cur_byte, rx_byte;
    logic [8*RD_BYTES-1:0] rd_acc;
    logic [1:0]            err_q;
    logic                  to_err, to_exp;
    logic                  last_stop, last_bit, tx_last, rx_last, accept;

    uart_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .mid     (mid),
        .tick    (tick)
    );

    assign cur_byte  = cmd_q[8*CMD_BYTES-1 -: 8];
    assign fall      = rx_d & ~rx_s;
    assign last_stop = (bit_idx == IW'(STOP_BITS - 1));
    assign last_bit  = (bit_idx == IW'(7));
    assign tx_last   = is_rd || (byte_idx == BYW'(CMD_BYTES - 1));
    assign rx_last   = (byte_idx == BYW'(RD_BYTES - 1));
    assign accept    = (state == IDLE) && cmd_vld;
    assign restart   = (state == IDLE) || ((state == RX_WAIT) && fall);

    assign cmd_rdy = (state == IDLE);
    assign rd_vld  = (state == DONE);
    assign rd_data = rd_acc;
    assign rd_err  = {to_err, err_q};

    // Two-flop synchroniser plus delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (cmd_vld) state_n = TX_START;
            TX_START: if (tick) state_n = TX_DATA;
            TX_DATA:  if (tick && last_bit)
                          state_n = (PARITY != PARITY_NONE) ? TX_PAR : TX_STOP;
            TX_PAR:   if (tick) state_n = TX_STOP;
            TX_STOP: begin
                if (tick && last_stop) begin
                    if (is_rd)             state_n = RX_WAIT;
                    else if (tx_last)      state_n = IDLE;
                    else if (GAP_BITS == 0) state_n = TX_START;
                    else                   state_n = TX_GAP;
                end
            end
            TX_GAP:   if (tick && bit_idx == IW'(GAP_BITS - 1)) state_n = TX_START;
            RX_WAIT: begin
                if (fall)        state_n = RX_START;
                else if (to_exp) state_n = DONE;
            end
            RX_START: begin
                if (mid && rx_s) state_n = RX_WAIT;
                else if (tick)   state_n = RX_DATA;
            end
            RX_DATA:  if (tick && last_bit)
                          state_n = (PARITY != PARITY_NONE) ? RX_PAR : RX_STOP;
            RX_PAR:   if (tick) state_n = RX_STOP;
            RX_STOP:  if (mid && last_stop) state_n = rx_last ? DONE : RX_WAIT;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Serial output decoded from the current state and byte
    always_comb begin
        tx = 1'b1;
        case (state)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = cur_byte[bit_idx[2:0]];
            TX_PAR:   tx = par_bit(cur_byte, PARITY);
            default:  tx = 1'b1;
        endcase
    end

    // Bit index: data bits, stop bits and gap bits within a state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx <= '0;
        end else if (state_n != state) begin
            bit_idx <= '0;
        end else if (tick && (state == TX_DATA || state == RX_DATA ||
                              state == TX_STOP || state == RX_STOP ||
                              state == TX_GAP)) begin
            bit_idx <= bit_idx + IW'(1);
        end
    end

    // Command shifting, byte index, rx assembly and error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q    <= '0;
            is_rd    <= 1'b0;
            byte_idx <= '0;
            rx_byte  <= '0;
            rd_acc   <= '0;
            err_q    <= '0;
        end else begin
            if (accept) begin
                cmd_q    <= cmd_in;
                is_rd    <= ~cmd_in[8*CMD_BYTES-1];
                byte_idx <= '0;
                rd_acc   <= '0;
                err_q    <= '0;
            end
            if (state == TX_STOP && tick && last_stop) begin
                if (is_rd) begin
                    byte_idx <= '0;
                end else if (!tx_last) begin
                    byte_idx <= byte_idx + BYW'(1);
                    cmd_q    <= cmd_q << 8;
                end
            end
            if (state == RX_DATA && mid)
                rx_byte <= {rx_s, rx_byte[7:1]};
            if (state == RX_PAR && mid && (rx_s != par_bit(rx_byte, PARITY)))
                err_q[0] <= 1'b1;
            if (state == RX_STOP && mid) begin
                if (!rx_s)
                    err_q[1] <= 1'b1;
                if (last_stop) begin
                    for (int i = 0; i < RD_BYTES; i++)
                        if (byte_idx == BYW'(i))
                            rd_acc[8*(RD_BYTES-1-i) +: 8] <= rx_byte;
                    if (!rx_last)
                        byte_idx <= byte_idx + BYW'(1);
                end
            end
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_BITS + 1);

    logic [TW-1:0] to_cnt;

    assign to_exp = tick && (to_cnt == TW'(TIMEOUT_BITS - 1));

    // Per-byte response timeout counted in bit-times while waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else begin
            if (state != RX_WAIT)
                to_cnt <= '0;
            else if (tick)
                to_cnt <= to_cnt + TW'(1);
            if (accept)
                to_err <= 1'b0;
            else if (state == RX_WAIT && !fall && to_exp)
                to_err <= 1'b1;
        end
    end
`else
    logic unused_to;

    assign unused_to = (TIMEOUT_BITS != 0);
    assign to_exp    = 1'b0;
    assign to_err    = 1'b0;
`endif

endmodule
